sbox_arbiter: RTL
=================

SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed as name / direction / width / meaning:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
REQ-002 The key-schedule requester ports SHALL be:
- ks_req  in  1  SubWord request
- ks_word  in  32  word to substitute
- ks_gnt  out  1  request accepted, ks_word captured
- ks_done  out  1  one-cycle result-valid pulse
- ks_result  out  32  substituted word
REQ-003 The state requester ports SHALL be:
- st_req  in  1  SubBytes request
- st_data  in  128  state to substitute
- st_gnt  out  1  request accepted, st_data captured
- st_done  out  1  one-cycle result-valid pulse
- st_result  out  128  substituted state
REQ-004 The block SHALL provide busy, an output of width 1, asserted whenever the FSM is not IDLE.

Function
REQ-005 The block SHALL share one 32-bit substitution lane (four byte S-boxes, AES forward table) between both requesters, performing one word lookup per cycle.
REQ-006 The FSM SHALL have exactly three states: IDLE, KS_RUN and ST_RUN.
REQ-007 Grants SHALL be combinational and issued only in IDLE: a request with no competitor SHALL be granted in the same cycle, and the matching input SHALL be captured on that edge.
REQ-008 A requester SHALL hold req and data stable until it sees gnt; data may change freely after gnt.
REQ-009 KS path timing SHALL be: gnt at T, IDLE->KS_RUN; lookup at T+1; ks_done=1 with ks_result valid at T+2, with the FSM back in IDLE at T+2.
REQ-010 ST path timing SHALL be: gnt at T; ST_RUN for T+1..T+4 processing word i = st_data[127-32i -: 32] for i=0..3; st_done=1 with st_result valid at T+5; IDLE at T+5.
REQ-011 In each word, byte j (bits [31-8j -: 8]) SHALL be substituted independently and SHALL keep its position.
REQ-012 A new grant SHALL be allowed in the same cycle as a done pulse, so back-to-back service has no idle bubble.
REQ-013 Requests arriving outside IDLE SHALL wait, with no grant and no loss.
REQ-014 ks_result and st_result SHALL each hold their value until that requester's next done pulse.
REQ-015 The done pulses SHALL be exactly one cycle wide and SHALL never assert together.
REQ-016 When both requests are present in IDLE in the same cycle, the winner SHALL be selected per REQ-020 and the loser SHALL be served after the winner's done.

Reset
REQ-017 While rst=1, the FSM SHALL go to IDLE, and ks_gnt, st_gnt, ks_done, st_done and busy SHALL be 0, and ks_result and st_result SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL abort the transaction with no done pulse, and the requester SHALL re-request.
REQ-019 No grant SHALL be issued in a cycle with rst=1.

Configuration
REQ-020 Macro SBOX_ARB_RR_EN SHALL select the arbitration policy on simultaneous requests:
- Undefined: fixed priority, KS always wins.
- Defined: round-robin; the requester not most recently granted wins, and the last-granted flag resets to ST (so KS wins the first tie).

Structure
REQ-021 Package sbox_arb_pkg SHALL hold:
- the FSM state typedef
- NUM_LANES=4
- WORDS_PER_STATE=4
REQ-022 A sub-module sbox_word SHALL wrap four existing SBox instances into a 32-bit combinational lane and be instantiated once.
REQ-023 The ST word index SHALL be a 2-bit counter that wraps 3->0 on the exit from ST_RUN.

Verification
REQ-024 KS single: ks_word=32'h00010203 granted at T -> ks_done at T+2, ks_result=32'h637c777b.
REQ-025 ST single: st_data=128'h000102030405060708090a0b0c0d0e0f -> st_done at T+5, st_result=128'h637c777bf26b6fc53001672bfed7ab76.
REQ-026 Simultaneous, both requests at T, macro undefined -> ks_gnt at T, st_gnt at T+2, st_done at T+7; with macro defined, a second tie -> ST wins.
REQ-027 Reset mid-ST: rst=1 at T+2 -> no st_done, busy=0 at T+3, all outputs 0.
REQ-028 Back-to-back: ks_req held high with ks_word=32'hffffffff -> gnt at T, T+2, T+4; ks_result=32'h16161616 each time.
REQ-029 Hold: st_req arriving at T+1 of a KS transaction -> no st_gnt until T+2.

Source files
------------

// File: rtl/sbox_arb_pkg.sv
// Shared types and sizing for the S-box arbiter: FSM state encoding and lane geometry.
package sbox_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KS_RUN = 2'd1,
        ST_RUN = 2'd2
    } arbState_t;

    localparam int NUM_LANES       = 4;
    localparam int WORDS_PER_STATE = 4;

endpackage

// File: rtl/SBox.sv
// AES forward S-box: one byte in, one substituted byte out, purely combinational.
module SBox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign byte_o = SBOX_TABLE[byte_i];

endmodule

// File: rtl/sbox_word.sv
// One 32-bit substitution lane: four byte S-boxes, each byte keeps its position in the word.
module sbox_word
    import sbox_arb_pkg::*;
(
    input  logic [8*NUM_LANES-1:0] word_i,
    output logic [8*NUM_LANES-1:0] word_o
);

    for (genvar j = 0; j < NUM_LANES; j++) begin : gLane
        SBox uSBox (
            .byte_i (word_i[8*NUM_LANES-1-8*j -: 8]),
            .byte_o (word_o[8*NUM_LANES-1-8*j -: 8])
        );
    end

endmodule

// File: rtl/sbox_arbiter.sv
// Arbitrates one shared S-box lane between a key-schedule word requester and a 128-bit state requester.
// Define SBOX_ARB_RR_EN for round-robin tie breaking; otherwise the key schedule always wins a tie.
module sbox_arbiter
    import sbox_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic         ks_req,
    input  logic [31:0]  ks_word,
    output logic         ks_gnt,
    output logic         ks_done,
    output logic [31:0]  ks_result,

    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_gnt,
    output logic         st_done,
    output logic [127:0] st_result,

    output logic         busy
);

    arbState_t    state_q;
    logic [1:0]   wordIdx_q;
    logic [31:0]  ksWord_q;
    logic [127:0] stData_q;
    logic [95:0]  stAcc_q;
    logic [95:0]  stAcc_d;
    logic [127:0] stResult_d;
    logic [31:0]  ksResult_q;
    logic [127:0] stResult_q;
    logic         ksDone_q;
    logic         stDone_q;
    logic         ksWins;
    logic [31:0]  laneIn;
    logic [31:0]  laneOut;

`ifdef SBOX_ARB_RR_EN
    logic         lastKs_q;

    // The requester not granted most recently wins a tie; flag starts at ST so KS wins the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastKs_q <= 1'b0;
        end else if (ks_gnt) begin
            lastKs_q <= 1'b1;
        end else if (st_gnt) begin
            lastKs_q <= 1'b0;
        end
    end

    assign ksWins = ks_req && (!st_req || !lastKs_q);
`else
    assign ksWins = ks_req;
`endif

    always_comb begin
        ks_gnt = 1'b0;
        st_gnt = 1'b0;
        if (!rst && state_q == IDLE) begin
            ks_gnt = ksWins;
            st_gnt = st_req && !ksWins;
        end
    end

    always_comb begin
        laneIn = ksWord_q;
        if (state_q == ST_RUN) begin
            case (wordIdx_q)
                2'd0:    laneIn = stData_q[127:96];
                2'd1:    laneIn = stData_q[95:64];
                2'd2:    laneIn = stData_q[63:32];
                default: laneIn = stData_q[31:0];
            endcase
        end
    end

    sbox_word uLane (
        .word_i (laneIn),
        .word_o (laneOut)
    );

    // Words accumulate off to the side so st_result only changes on its done pulse.
    assign stAcc_d    = {stAcc_q[63:0], laneOut};
    assign stResult_d = {stAcc_q, laneOut};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wordIdx_q  <= 2'd0;
            ksWord_q   <= '0;
            stData_q   <= '0;
            stAcc_q    <= '0;
            ksResult_q <= '0;
            stResult_q <= '0;
            ksDone_q   <= 1'b0;
            stDone_q   <= 1'b0;
        end else begin
            ksDone_q <= 1'b0;
            stDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ks_gnt) begin
                        ksWord_q <= ks_word;
                        state_q  <= KS_RUN;
                    end else if (st_gnt) begin
                        stData_q <= st_data;
                        state_q  <= ST_RUN;
                    end
                end
                KS_RUN: begin
                    ksResult_q <= laneOut;
                    ksDone_q   <= 1'b1;
                    state_q    <= IDLE;
                end
                ST_RUN: begin
                    wordIdx_q <= wordIdx_q + 2'd1;
                    if (wordIdx_q == 2'(WORDS_PER_STATE - 1)) begin
                        stResult_q <= stResult_d;
                        stDone_q   <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        stAcc_q <= stAcc_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ks_done   = ksDone_q;
    assign st_done   = stDone_q;
    assign ks_result = ksResult_q;
    assign st_result = stResult_q;
    assign busy      = (state_q != IDLE);

endmodule
